// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Desc   : Shared constants and state encoding for the digit-serial BCD adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;
    localparam int BCD_CORR  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return d > DIGIT_W'(DIGIT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adder.sv
// ============================================================================
// Module : bcd_digit_adder
// Desc   : Combinational single-digit BCD adder with decimal-carry correction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);

    logic [DIGIT_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
        if (raw > (DIGIT_W+1)'(DIGIT_MAX)) begin
            s  = raw[DIGIT_W-1:0] + DIGIT_W'(BCD_CORR);
            co = 1'b1;
        end else begin
            s  = raw[DIGIT_W-1:0];
            co = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_adder.sv
// ============================================================================
// Module : bcd_serial_adder
// Desc   : Digit-serial BCD adder/subtractor, LSD first, start/busy/done.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [4*DIGITS-1:0]    a,
    input  logic [4*DIGITS-1:0]    b,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    sum,
    output logic                   cout,
    output logic                   invalid
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic [W-1:0]       res_sh_q, res_sh_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic               inv_q, inv_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               inv_out_q, inv_out_d;

    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] dig_s;
    logic               dig_co;
    logic [W-1:0]       res_next;
    logic               in_bad;
    logic               last_dig;

    // Subtraction feeds the nine's complement of B; invalid digits wrap in 4 bits.
    assign b_dig = sub_q ? (DIGIT_W'(DIGIT_MAX) - b_sh_q[DIGIT_W-1:0])
                         : b_sh_q[DIGIT_W-1:0];

    bcd_digit_adder u_digit (
        .a  (a_sh_q[DIGIT_W-1:0]),
        .b  (b_dig),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    assign res_next = W'({dig_s, res_sh_q} >> DIGIT_W);
    assign last_dig = (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_bad(a[i*DIGIT_W +: DIGIT_W]) || digit_bad(b[i*DIGIT_W +: DIGIT_W]))
                in_bad = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_dig) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state_q == RUN) || (state_q == DONE);
        done    = (state_q == DONE);
        sum     = sum_q;
        cout    = cout_q;
        invalid = inv_out_q;
    end

    always_comb begin
        idx_d     = idx_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_sh_d  = res_sh_q;
        sub_d     = sub_q;
        carry_d   = carry_q;
        inv_d     = inv_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        inv_out_d = inv_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    sub_d   = sub;
                    carry_d = sub | cin;
                    inv_d   = in_bad;
                    idx_d   = '0;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> DIGIT_W;
                b_sh_d   = b_sh_q >> DIGIT_W;
                res_sh_d = res_next;
                carry_d  = dig_co;
                idx_d    = idx_q + IDX_W'(1);
                if (last_dig) begin
                    sum_d     = res_next;
                    cout_d    = dig_co;
                    inv_out_d = inv_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            res_sh_q  <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            inv_q     <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            inv_out_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            res_sh_q  <= res_sh_d;
            sub_q     <= sub_d;
            carry_q   <= carry_d;
            inv_q     <= inv_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            inv_out_q <= inv_out_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
// ============================================================================
// Module : tb_bcd_serial_adder
// Desc   : Directed self-checking bench for bcd_serial_adder (DIGITS=4 and 1).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, invalid;
    logic [15:0] sum;

    logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, cout1, invalid1;
    logic [3:0]  sum1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .invalid(invalid)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .sub(sub1), .cin(cin1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .invalid(invalid1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency counts clock edges from the start edge inclusive up to DONE.
    task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic isub, input logic icin,
                         input logic [15:0] esum, input logic ecout, input logic einv);
        int lat;
        @(negedge clk);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = ~isub;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"},  lat,     5);
        check({tag, "_sum"},  sum,     esum);
        check({tag, "_cout"}, cout,    ecout);
        check({tag, "_inv"},  invalid, einv);
        @(negedge clk);
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
        check({tag, "_sum_held"}, sum, esum);
    endtask

    initial begin
        int lat;
        int n_done;
        int busy_drop;

        #12;
        check("rst_outputs", {busy, done, sum, cout, invalid}, '0);
        @(negedge clk);
        resetn = 1'b1;

        do_op("add1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        do_op("add9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add0009_cin",  16'h0009, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
        do_op("sub42_17",     16'h0042, 16'h0017, 1'b1, 1'b0, 16'h0025, 1'b1, 1'b0);
        do_op("sub17_42",     16'h0017, 16'h0042, 1'b1, 1'b0, 16'h9975, 1'b0, 1'b0);
        do_op("sub42_17_cin", 16'h0042, 16'h0017, 1'b1, 1'b1, 16'h0025, 1'b1, 1'b0);

        // Second start during RUN must be ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0; busy_drop = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                a = 16'h1111; b = 16'h1111; cin = 1'b1; start = 1'b1;
            end else if (i == 2) begin
                start = 1'b0;
            end
            if (done) n_done++;
            if (i < 4 && !busy) busy_drop++;
            if (done) check("restart_sum", sum, 16'h6912);
            @(negedge clk);
        end
        check("restart_ndone", n_done, 1);
        check("restart_busy", busy_drop, 0);

        do_op("invalid_00A0", 16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);

        // Reset in the cycle after start aborts; prior held outputs clear.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        resetn = 1'b0;
        #1;
        check("abort_outputs", {busy, done, sum, cout, invalid}, '0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        resetn = 1'b1;
        do_op("after_abort", 16'h0500, 16'h0499, 1'b0, 1'b0, 16'h0999, 1'b0, 1'b0);

        // DIGITS=1 instance: 5+7 -> 2 carry 1, latency 2.
        @(negedge clk);
        a1 = 4'h5; b1 = 4'h7; start1 = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("d1_lat",  lat,   2);
        check("d1_sum",  sum1,  4'h2);
        check("d1_cout", cout1, 1'b1);
        check("d1_inv",  invalid1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
